// File: rtl/jpeg_pkg.sv
// Shared JPEG decode definitions: block size, zigzag-to-raster map, write FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package jpeg_pkg;

  localparam int BLK_SIZE = 64;

  // Raster position (row*8 + col) of each coefficient, indexed by its zigzag step
  localparam logic [5:0] ZZ_TO_RASTER [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Write-side states: WRITE accepts input, FILL zero-pads a block cut short by in_last
  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_FILL  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank 64-entry coefficient store with one synchronous write port and one combinational read port.
// Latency: write lands at the clock edge; read data follows rd_bank/rd_addr combinationally.
// Backpressure: none; the controller guarantees the read and write banks never coincide.
module pingpong_ram
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][BLK_SIZE];

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/izigzag_buffer.sv
// Inverse zigzag reorder: zigzag-order 8x8 blocks in, raster-order out, ping-pong banks, 1 sample/cycle.
// Latency: first raster output valid one cycle after the edge accepting a block's 64th input.
// Backpressure: in_ready drops while the write bank is still full; output holds while out_ready is low.
// Optional macro IZIGZAG_EOB_FILL_EN: in_last ends a block early and the remainder is zero-filled.
module izigzag_buffer
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  wr_state_t         state, state_nxt;
  logic              wbank, rbank;
  logic [1:0]        full;
  logic [1:0]        full_set, full_clr;
  logic [5:0]        wcnt, rcnt;
  logic              in_fire, fill_active, we, wr_done;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              load, rd_done;

`ifndef IZIGZAG_EOB_FILL_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  // Write-side handshake, RAM write port and FSM next state
  always_comb begin
    fill_active = 1'b0;
    state_nxt   = state;
`ifdef IZIGZAG_EOB_FILL_EN
    fill_active = (state == ST_FILL);
`endif
    in_ready = !full[wbank] && (state == ST_WRITE);
    in_fire  = in_valid && in_ready;
    we       = in_fire || fill_active;
    wr_addr  = ZZ_TO_RASTER[wcnt];
    wr_data  = fill_active ? '0 : in_data;
    wr_done  = we && (wcnt == 6'd63);
`ifdef IZIGZAG_EOB_FILL_EN
    // in_last on the 64th sample is an ordinary completion, so only early ends enter FILL
    if (in_fire && in_last && !wr_done) begin
      state_nxt = ST_FILL;
    end else if (fill_active && wr_done) begin
      state_nxt = ST_WRITE;
    end
`endif
  end

  // Read-side load decision and bank full/free events
  always_comb begin
    load     = full[rbank] && (!out_valid || out_ready);
    rd_done  = load && (rcnt == 6'd63);
    full_set = wr_done ? (2'b01 << wbank) : 2'b00;
    full_clr = rd_done ? (2'b01 << rbank) : 2'b00;
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WRITE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write address counter and write-bank toggle at block completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (we) begin
      wcnt <= wcnt + 6'd1;
      if (wr_done) begin
        wbank <= ~wbank;
      end
    end
  end

  // Bank occupancy; set and clear always hit different banks, so both apply independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  // Output register: load the next raster sample, or drop valid once the last one is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      rcnt      <= '0;
      rbank     <= 1'b0;
    end else if (load) begin
      out_data  <= rd_data;
      out_last  <= (rcnt == 6'd63);
      out_valid <= 1'b1;
      rcnt      <= rcnt + 6'd1;
      if (rd_done) begin
        rbank <= ~rbank;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Reader only touches a full bank and the writer only a non-full one, so ports never collide
  pingpong_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_bank (wbank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rbank),
    .rd_addr (rcnt),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_izigzag_buffer.sv
// Self-checking bench for izigzag_buffer: reference reorders blocks using an arithmetic zigzag walk.
// Latency: checks first-output timing and streaming throughput.
// Backpressure: exercises out_ready stalls and random valid/ready patterns.
module tb_izigzag_buffer;

  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  always #5 clk = ~clk;

  izigzag_buffer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  int                scan[64];
  logic [DATA_W-1:0] blk[64];
  int                in_pos;
  int                blocks_done;
  int                lasts_seen;
  int                checks;
  int                fails;

  // Zigzag walk over anti-diagonals: odd diagonals run down-left, even ones up-right
  function automatic void build_scan();
    int k;
    int r;
    int c;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int i = 0; i < 8; i++) begin
        r = (s % 2 == 1) ? i : 7 - i;
        c = s - r;
        if (c >= 0 && c < 8) begin
          scan[k] = r * 8 + c;
          k++;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    in_pos = 0;
  endfunction

  // Reference: place each accepted sample at its raster slot; emit the block when complete
  function automatic void model_accept(logic [DATA_W-1:0] d, logic last);
    exp_t e;
    if (last) lasts_seen++;
    blk[scan[in_pos]] = d;
    in_pos++;
`ifdef IZIGZAG_EOB_FILL_EN
    if (last && in_pos < 64) begin
      while (in_pos < 64) begin
        blk[scan[in_pos]] = '0;
        in_pos++;
      end
    end
`endif
    if (in_pos == 64) begin
      for (int i = 0; i < 64; i++) begin
        e.data = blk[i];
        e.last = (i == 63);
        exp_q.push_back(e);
      end
      in_pos = 0;
      blocks_done++;
    end
  endfunction

  // One clock: sample handshakes just after the driving edge, update the model, move to the next negedge
  task automatic tick(output bit ia, output bit oa, output bit ir, output bit ov,
                      output logic [DATA_W-1:0] od, output logic ol);
    #1;
    ir = in_ready;
    ov = out_valid;
    ia = in_valid && in_ready;
    oa = out_valid && out_ready;
    od = out_data;
    ol = out_last;
    if (ia) model_accept(in_data, in_last);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int sent, outs, cyc, last_cnt;
    int rast[64];
    int exp_first[12] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4, 7, 13};
    sent = 0; outs = 0; cyc = 0; last_cnt = 0;
    out_ready = 1'b1;
    while (sent < 64 && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(sent);
      tick(ia, oa, ir, ov, od, ol);
      if (ia) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_latency_early: out_valid %b want 0 one edge after last input", out_valid); end
    tick(ia, oa, ir, ov, od, ol);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_latency: out_valid %b want 1 two edges after last input", out_valid); end
    cyc = 0;
    while (outs < 64 && cyc < 300) begin
      tick(ia, oa, ir, ov, od, ol);
      if (oa) begin
        rast[outs] = int'(od);
        if (ol) last_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL single_extra: unexpected output %h", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.data || ol !== e.last) begin
            fails++; $display("FAIL single_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
          end
        end
        checks++;
        if (ol !== (outs == 63)) begin fails++; $display("FAIL single_last[%0d]: got %b want %b", outs, ol, outs == 63); end
        outs++;
      end
      cyc++;
    end
    checks++; if (outs != 64) begin fails++; $display("FAIL single_count: got %0d outputs want 64", outs); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (rast[i] != exp_first[i]) begin fails++; $display("FAIL single_raster%0d: got %0d want %0d", i, rast[i], exp_first[i]); end
    end
    checks++; if (rast[16] != 3) begin fails++; $display("FAIL single_raster16: got %0d want 3", rast[16]); end
    checks++; if (rast[63] != 63) begin fails++; $display("FAIL single_raster63: got %0d want 63", rast[63]); end
    checks++; if (last_cnt != 1) begin fails++; $display("FAIL single_last_count: got %0d want 1", last_cnt); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int sent, outs, cyc, gaps, drops;
    bit started, sending;
    sent = 0; outs = 0; cyc = 0; gaps = 0; drops = 0; started = 0;
    out_ready = 1'b1;
    while (outs < 256 && cyc < 1000) begin
      sending  = (sent < 256);
      in_valid = sending;
      in_data  = DATA_W'($urandom);
      tick(ia, oa, ir, ov, od, ol);
      if (ia) sent++;
      if (sending && !ir) drops++;
      if (oa) begin
        started = 1;
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_extra: unexpected output %h", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.data || ol !== e.last) begin
            fails++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
          end
        end
        outs++;
      end else if (started) begin
        gaps++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (outs != 256) begin fails++; $display("FAIL b2b_count: got %0d outputs want 256", outs); end
    checks++; if (gaps != 0) begin fails++; $display("FAIL b2b_gaps: got %0d bubbles want 0", gaps); end
    checks++; if (drops != 0) begin fails++; $display("FAIL b2b_in_ready: dropped %0d cycles want 0", drops); end
  endtask

  task automatic test_backpressure();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int acc, first_drop, hold_bad, outs, cyc;
    acc = 0; first_drop = -1; hold_bad = 0; outs = 0; cyc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick(ia, oa, ir, ov, od, ol);
      if (!ir && first_drop < 0) first_drop = acc;
      if (ia) acc++;
      if (ov && exp_q.size() > 0 && od !== exp_q[0].data) hold_bad++;
    end
    checks++; if (first_drop != 128) begin fails++; $display("FAIL bp_drop_point: in_ready fell after %0d inputs want 128", first_drop); end
    checks++; if (acc != 128) begin fails++; $display("FAIL bp_accepted: got %0d inputs want 128", acc); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_held: out_valid %b want 1", out_valid); end
    checks++; if (exp_q.size() == 0 || out_data !== exp_q[0].data) begin fails++; $display("FAIL bp_data_held: out_data %h not the raster0 value", out_data); end
    checks++; if (hold_bad != 0) begin fails++; $display("FAIL bp_hold_stable: %0d cycles with changed data want 0", hold_bad); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 400) begin
      tick(ia, oa, ir, ov, od, ol);
      if (oa) begin
        checks++;
        e = exp_q.pop_front();
        if (od !== e.data || ol !== e.last) begin
          fails++; $display("FAIL bp_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
        end
        outs++;
      end
      cyc++;
    end
    checks++; if (outs != 128) begin fails++; $display("FAIL bp_count: got %0d outputs want 128", outs); end
  endtask

  task automatic test_random();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int target, outs, cyc;
    outs = 0; cyc = 0;
    target = blocks_done + 20;
    while ((blocks_done < target || exp_q.size() != 0) && cyc < 20000) begin
      in_valid  = (blocks_done < target) && ($urandom_range(1, 0) == 1);
      in_data   = DATA_W'($urandom);
      in_last   = ($urandom_range(15, 0) == 0);
      out_ready = ($urandom_range(1, 0) == 1);
      tick(ia, oa, ir, ov, od, ol);
      if (oa) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_extra: unexpected output %h", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.data || ol !== e.last) begin
            fails++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
          end
        end
        outs++;
      end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    $display("random: %0d outputs, %0d in_last markers seen", outs, lasts_seen);
    checks++; if (cyc >= 20000) begin fails++; $display("FAIL rand_timeout: %0d outputs pending", exp_q.size()); end
    checks++; if (outs != 1280) begin fails++; $display("FAIL rand_count: got %0d outputs want 1280", outs); end
  endtask

  task automatic test_reset_midstream();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int sent, outs, cyc;
    sent = 0; outs = 0; cyc = 0;
    out_ready = 1'b1; in_last = 1'b0;
    while (sent < 94 && cyc < 300) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick(ia, oa, ir, ov, od, ol);
      if (ia) sent++;
      if (oa) begin
        checks++;
        e = exp_q.pop_front();
        if (od !== e.data || ol !== e.last) begin fails++; $display("FAIL mid_pre_data: got %h want %h", od, e.data); end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: out_valid %b want 1 before reset", out_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: out_valid %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_async_ready: in_ready %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sent = 0; cyc = 0;
    while ((sent < 64 || exp_q.size() != 0) && cyc < 400) begin
      in_valid = (sent < 64);
      in_data  = DATA_W'($urandom);
      tick(ia, oa, ir, ov, od, ol);
      if (ia) sent++;
      if (oa) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL mid_extra: stale output %h after reset", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.data || ol !== e.last) begin
            fails++; $display("FAIL mid_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
          end
        end
        outs++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (outs != 64) begin fails++; $display("FAIL mid_count: got %0d outputs want 64", outs); end
  endtask

`ifdef IZIGZAG_EOB_FILL_EN
  task automatic test_eob_fill();
    bit ia, oa, ir, ov;
    logic [DATA_W-1:0] od;
    logic ol;
    exp_t e;
    int sent, prev_sent, outs, cyc, low, nonzero, sum;
    bit reopened;
    sent = 0; outs = 0; cyc = 0; low = 0; nonzero = 0; sum = 0; reopened = 0;
    out_ready = 1'b1;
    while ((sent < 10 || outs < 64) && cyc < 400) begin
      in_valid  = (sent < 10);
      in_data   = DATA_W'(sent + 1);
      in_last   = (sent == 9);
      prev_sent = sent;
      tick(ia, oa, ir, ov, od, ol);
      if (ia) sent++;
      if (prev_sent == 10 && !reopened) begin
        if (ir) reopened = 1;
        else low++;
      end
      if (oa) begin
        if (od != 0) nonzero++;
        sum += int'(od);
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL eob_extra: unexpected output %h", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e.data || ol !== e.last) begin
            fails++; $display("FAIL eob_data[%0d]: got %h/%b want %h/%b", outs, od, ol, e.data, e.last);
          end
        end
        outs++;
      end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (low != 54) begin fails++; $display("FAIL eob_fill_cycles: in_ready low %0d cycles want 54", low); end
    checks++; if (outs != 64) begin fails++; $display("FAIL eob_count: got %0d outputs want 64", outs); end
    checks++; if (nonzero != 10 || sum != 55) begin fails++; $display("FAIL eob_contents: %0d nonzero sum %0d want 10 and 55", nonzero, sum); end
  endtask
`endif

  initial begin
    checks = 0; fails = 0; blocks_done = 0; lasts_seen = 0; in_pos = 0;
    build_scan();
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
`ifdef IZIGZAG_EOB_FILL_EN
    test_eob_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
